myproject_mul_arb: RTL and testbench
====================================

MYPROJECT_MUL_ARB -- requirements
Module: myproject_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the multiplier.
REQ-002 SHALL have parameter DIN0_WIDTH, default 19, signed operand A width.
REQ-003 SHALL have parameter DIN1_WIDTH, default 16, signed operand B width.
REQ-004 SHALL have parameter DOUT_WIDTH, default 35, product width (DIN0_WIDTH+DIN1_WIDTH).
REQ-005 SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port ap_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester operand-pair valid.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand A, requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH].
REQ-010 SHALL have port req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand B, same packing.
REQ-011 SHALL have port rsp_valid  out  1  product register holds a result.
REQ-012 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-013 SHALL have port rsp_dout  out  DOUT_WIDTH  signed product.
REQ-014 SHALL have port rsp_id  out  clog2(NUM_REQ)  index of requester that produced rsp_dout.

Function
REQ-015 SHALL contain exactly one combinational signed DIN0_WIDTH x DIN1_WIDTH multiplier, shared by all requesters.
REQ-016 Output stage SHALL be a two-state FSM: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-017 Slot is open when state=EMPTY, or state=FULL and rsp_ready=1 (same-cycle drain and refill).
REQ-018 When slot open and any req_valid=1, SHALL assert req_ready for exactly one granted requester; otherwise req_ready=0.
REQ-019 req_ready SHALL depend combinationally on req_valid, rsp_ready and state only, never on operand data.
REQ-020 On grant (req_valid[g]&req_ready[g]), next edge SHALL load rsp_dout = $signed(din0[g]) * $signed(din1[g]), full precision, no truncation, rsp_id=g, state=FULL.
REQ-021 Latency SHALL be exactly one cycle from grant edge to rsp_valid=1.
REQ-022 FULL with rsp_ready=1 and no grant SHALL go EMPTY; FULL with rsp_ready=0 SHALL hold rsp_dout/rsp_id stable.
REQ-023 Sustained throughput SHALL be one product per cycle while rsp_ready=1 and requests pending.
REQ-024 Priority pointer ptr SHALL update only on a grant, to (g+1) mod NUM_REQ; wraps NUM_REQ-1 -> 0.
REQ-025 Requester deasserting req_valid without grant SHALL simply lose arbitration; no state change.

Reset
REQ-026 ap_rst=1 SHALL immediately force state=EMPTY, rsp_valid=0, req_ready=0, rsp_dout=0, rsp_id=0, ptr=0.
REQ-027 Reset mid-operation SHALL discard the held product; first grant after release follows ptr=0.
REQ-028 Outputs SHALL remain at reset values for the whole reset assertion regardless of inputs.

Configuration
REQ-029 Macro MYPROJECT_MUL_ARB_ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-030 Defined: grant first valid requester scanning ptr, ptr+1, ... wrapping (round-robin, starvation-free).
REQ-031 Undefined: fixed priority, lowest index wins; ptr register SHALL not exist; interface unchanged.

Verification
REQ-032 Single request: req_valid=0001, din0=-3, din1=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_dout=-21, rsp_id=0.
REQ-033 Extremes: din0=-262144, din1=-32768 -> rsp_dout=8589934592 (35-bit, no overflow); din0=262143, din1=-32768 -> -8589901824.
REQ-034 All four valid every cycle, rsp_ready=1, RR_EN defined -> rsp_id sequence 0,1,2,3,0,...; undefined -> 0,0,0,...
REQ-035 Backpressure: FULL, rsp_ready=0 for 3 cycles with pending requests -> req_ready=0000, rsp_dout stable; rsp_ready=1 -> drain and refill same cycle, no bubble.
REQ-036 Assert ap_rst asynchronously mid-cycle while FULL -> rsp_valid drops before next edge; after release requester 0 granted first.

Source files
------------

// File: rtl/myproject_mul_arb.sv
// Shared signed multiplier with N-way arbitration and a one-entry registered output slot.
// Define MYPROJECT_MUL_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module myproject_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 19,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 35,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic [IDW-1:0]                   rsp_id
);

  localparam int unsigned NREQ = NUM_REQ;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;

  logic                         slot_open;
  logic                         gnt_any;
  logic [IDW-1:0]               gnt_idx;
  logic [NUM_REQ-1:0]           gnt_vec;
  logic                         take;
  logic [DIN0_WIDTH-1:0]        a_sel;
  logic [DIN1_WIDTH-1:0]        b_sel;
  logic signed [DOUT_WIDTH-1:0] a_ext;
  logic signed [DOUT_WIDTH-1:0] b_ext;
  logic signed [DOUT_WIDTH-1:0] prod;

`ifdef MYPROJECT_MUL_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;

  // Scan starts at ptr and wraps; the first valid requester found wins.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int unsigned'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any      = 1'b1;
        gnt_idx      = IDW'(idx);
        gnt_vec[idx] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[k]) begin
        gnt_any    = 1'b1;
        gnt_idx    = IDW'(k);
        gnt_vec[k] = 1'b1;
      end
    end
  end
`endif

  // Reset gates req_ready so no requester sees an accept while the slot is being cleared.
  assign slot_open = (state == EMPTY) || rsp_ready;
  assign take      = slot_open && gnt_any;
  assign req_ready = (take && !ap_rst) ? gnt_vec : '0;

  always_comb begin
    a_sel = req_din0[gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
    b_sel = req_din1[gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];
    a_ext = DOUT_WIDTH'($signed(a_sel));
    b_ext = DOUT_WIDTH'($signed(b_sel));
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_dout  <= '0;
      rsp_id    <= '0;
`ifdef MYPROJECT_MUL_ARB_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else begin
      if (take) begin
        state     <= FULL;
        rsp_valid <= 1'b1;
        rsp_dout  <= prod;
        rsp_id    <= gnt_idx;
`ifdef MYPROJECT_MUL_ARB_ROUND_ROBIN_EN
        ptr       <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
      end else if (state == FULL && rsp_ready) begin
        state     <= EMPTY;
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Directed self-checking bench for myproject_mul_arb (4 requesters, 19x16 -> 35 bits).
module tb_myproject_mul_arb;

  logic              ap_clk;
  logic              ap_rst;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][18:0]  req_din0;
  logic [3:0][15:0]  req_din1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [34:0]       rsp_dout;
  logic [1:0]        rsp_id;

  int n_checks;
  int n_fail;

  myproject_mul_arb #(
    .NUM_REQ(4),
    .DIN0_WIDTH(19),
    .DIN1_WIDTH(16),
    .DOUT_WIDTH(35)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_din0(req_din0),
    .req_din1(req_din1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout),
    .rsp_id(rsp_id)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]        valid;
    logic [3:0][18:0]  d0;
    logic [3:0][15:0]  d1;
    logic [3:0]        exp_ready;
    logic              exp_valid;
    logic signed [34:0] exp_dout;
    logic [1:0]        exp_id;
  } vec_t;

  vec_t vecs[6];

  // Non-granted lanes carry filler data so a wrong operand mux shows up in the product.
  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] exp_ready,
                              input logic exp_valid, input logic signed [34:0] exp_dout,
                              input logic [1:0] exp_id);
    vec_t v;
    v.valid     = valid;
    v.exp_ready = exp_ready;
    v.exp_valid = exp_valid;
    v.exp_dout  = exp_dout;
    v.exp_id    = exp_id;
    for (int i = 0; i < 4; i++) begin
      v.d0[i] = 19'd5;
      v.d1[i] = 16'd9;
    end
    return v;
  endfunction

  logic signed [34:0] lane_exp[4];
  logic signed [34:0] hold_dout;
  logic [1:0]         hold_id;
  logic [1:0]         exp_id;
  logic signed [34:0] exp_dout;

  task automatic load_lanes(input logic signed [15:0] b_override, input logic use_override);
    for (int i = 0; i < 4; i++) begin
      req_din0[i] = 19'(100 * (i + 1));
      req_din1[i] = use_override ? b_override : 16'(-(i + 2));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_din0  = '0;
    req_din1  = '0;
    lane_exp[0] = -35'sd200;
    lane_exp[1] = -35'sd600;
    lane_exp[2] = -35'sd1200;
    lane_exp[3] = -35'sd2000;

    vecs[0] = mk(4'b0001, 4'b0001, 1'b1, -35'sd21, 2'd0);
    vecs[0].d0[0] = -19'sd3;      vecs[0].d1[0] = 16'sd7;
    vecs[1] = mk(4'b0100, 4'b0100, 1'b1, 35'sd8589934592, 2'd2);
    vecs[1].d0[2] = -19'sd262144; vecs[1].d1[2] = -16'sd32768;
    vecs[2] = mk(4'b1000, 4'b1000, 1'b1, -35'sd8589901824, 2'd3);
    vecs[2].d0[3] = 19'sd262143;  vecs[2].d1[3] = -16'sd32768;
    vecs[3] = mk(4'b0000, 4'b0000, 1'b0, 35'sd0, 2'd0);
    vecs[4] = mk(4'b0010, 4'b0010, 1'b1, -35'sd12345, 2'd1);
    vecs[4].d0[1] = 19'sd12345;   vecs[4].d1[1] = -16'sd1;
    vecs[5] = mk(4'b0001, 4'b0001, 1'b1, 35'sd1, 2'd0);
    vecs[5].d0[0] = -19'sd1;      vecs[5].d1[0] = -16'sd1;

    // Reset held across edges with requests pending: everything stays at reset values.
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_dout", rsp_dout, 0);
    chk("rst_id", rsp_id, 0);

    @(negedge ap_clk);
    ap_rst    = 1'b0;
    req_valid = '0;

    for (int v = 0; v < 6; v++) begin
      @(negedge ap_clk);
      req_valid = vecs[v].valid;
      req_din0  = vecs[v].d0;
      req_din1  = vecs[v].d1;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
      @(posedge ap_clk);
      #1;
      chk($sformatf("vec%0d_valid", v), rsp_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d_dout", v), $signed(rsp_dout), vecs[v].exp_dout);
        chk($sformatf("vec%0d_id", v), rsp_id, vecs[v].exp_id);
      end
    end

    // Drain, then all four requesters contend every cycle.
    @(negedge ap_clk);
    req_valid = '0;
    @(posedge ap_clk);
    #1;
    chk("drain_valid", rsp_valid, 0);

    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    load_lanes(16'sd0, 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef MYPROJECT_MUL_ARB_ROUND_ROBIN_EN
      exp_id = 2'(k % 4);
`else
      exp_id = 2'd0;
`endif
      #1;
      chk($sformatf("arb%0d_ready", k), req_ready, 4'b0001 << exp_id);
      @(posedge ap_clk);
      #1;
      chk($sformatf("arb%0d_valid", k), rsp_valid, 1);
      chk($sformatf("arb%0d_id", k), rsp_id, exp_id);
      chk($sformatf("arb%0d_dout", k), $signed(rsp_dout), lane_exp[exp_id]);
      @(negedge ap_clk);
    end

    // Backpressure: slot stays full and closed for three cycles, then drains and refills together.
`ifdef MYPROJECT_MUL_ARB_ROUND_ROBIN_EN
    hold_id = 2'd1;
`else
    hold_id = 2'd0;
`endif
    hold_dout = lane_exp[hold_id];
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), req_ready, 0);
      @(posedge ap_clk);
      #1;
      chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
      chk($sformatf("bp%0d_dout", k), $signed(rsp_dout), hold_dout);
      chk($sformatf("bp%0d_id", k), rsp_id, hold_id);
      @(negedge ap_clk);
    end
    load_lanes(16'sd3, 1'b1);
    rsp_ready = 1'b1;
`ifdef MYPROJECT_MUL_ARB_ROUND_ROBIN_EN
    exp_id   = 2'd2;
    exp_dout = 35'sd900;
`else
    exp_id   = 2'd0;
    exp_dout = 35'sd300;
`endif
    #1;
    chk("refill_ready", req_ready, 4'b0001 << exp_id);
    @(posedge ap_clk);
    #1;
    chk("refill_valid", rsp_valid, 1);
    chk("refill_id", rsp_id, exp_id);
    chk("refill_dout", $signed(rsp_dout), exp_dout);

    // Asynchronous reset between edges while full.
    @(negedge ap_clk);
    load_lanes(16'sd0, 1'b0);
    rsp_ready = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_dout", rsp_dout, 0);
    chk("arst_id", rsp_id, 0);
    chk("arst_ready", req_ready, 0);
    @(posedge ap_clk);
    #1;
    chk("arst_hold_valid", rsp_valid, 0);
    chk("arst_hold_ready", req_ready, 0);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 4'b0001);
    @(posedge ap_clk);
    #1;
    chk("post_rst_valid", rsp_valid, 1);
    chk("post_rst_id", rsp_id, 0);
    chk("post_rst_dout", $signed(rsp_dout), lane_exp[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
